fifo_rd_ctrl: RTL
=================

# fifo_rd_ctrl

Read-side controller for the asynchronous FIFO, running entirely in the read clock domain. It synchronises the Gray-coded write pointer, derives empty and occupancy, and drives `rd_en`/`read_ptr` into the dual-clock BRAM. It absorbs the BRAM's one-cycle read latency and its zero-when-idle output into a 2-entry output buffer, and presents a valid/ready stream to the consumer (e.g. MAC TX path). It is the reader counterpart to the write-side logic that fills the BRAM.

## Interface
- `WIDTH`, 8: data word width.
- `PTR_LEN`, 4: address bits; FIFO depth = 2^PTR_LEN. Pointers are PTR_LEN+1 bits, and the MSB is the wrap bit.

- `rd_clk` in 1: read-domain clock. Single clock for the whole block.
- `rd_rst_n` in 1: asynchronous, active-low reset.
- `wr_ptr_gray` in PTR_LEN+1: Gray write pointer from the write domain. Asynchronous to `rd_clk`.
- `rd_ptr_gray` out PTR_LEN+1: registered Gray read pointer, sent to the write domain.
- `read_ptr` out PTR_LEN+1: registered binary read pointer, sent to the BRAM.
- `rd_en` out 1: BRAM read strobe.
- `bram_data` in WIDTH: BRAM `data_out`. Valid for exactly the cycle after an `rd_en` cycle; 0 otherwise.
- `m_data` out WIDTH: output data (buffer head).
- `m_valid` out 1: `m_data` is valid.
- `m_ready` in 1: consumer accepts the word.
- `empty` out 1: no unfetched entries in the BRAM (synchronised view).
- `level` out PTR_LEN+1: unfetched BRAM entries, computed as sync_wr_bin − read_ptr modulo 2^(PTR_LEN+1).

## Operation
- **Synchroniser:** two flops, `wr_ptr_gray` → s1 → s2. Only s2 is used. sync_wr_bin = gray2bin(s2).
- **Empty:** `empty` = (s2 == `rd_ptr_gray`). It is combinational from registers.
- **Fetch:**
  - `rd_en` = !empty && (occ + inflight − pop) < 2.
  - occ = buffered words (0..2).
  - inflight = `rd_en` was high in the previous cycle.
  - pop = `m_valid` && `m_ready`.
- **Pointer update:** on an `rd_en` cycle, `read_ptr` += 1 and `rd_ptr_gray` = bin2gray(`read_ptr`+1). Both registers update on the same edge.
- **Wrap-around:** natural PTR_LEN+1-bit rollover.
- **Capture:** in the cycle after `rd_en`, `bram_data` is written into the buffer. This must happen in that cycle because the BRAM drives 0 on the following cycle.
- **Output buffer:** 2-entry FIFO. `m_data` = head, `m_valid` = occ != 0.
  - Push and pop in the same cycle is legal; occ is unchanged and order is preserved.
  - Overflow is impossible by construction of the fetch rule. The bench asserts occ + inflight ≤ 2.
- **Stability:** `m_data` is held stable while `m_valid` && !`m_ready`.
- **Occupancy:** `level` counts BRAM entries only. Buffered and in-flight words are excluded.

## Timing
- **Reset values:** all outputs 0 (`read_ptr`, `rd_ptr_gray`, `rd_en`, `m_data`, `m_valid`, `level`), except `empty` = 1. s1, s2, occ and inflight are also cleared to 0.
- **Reset mid-operation:** buffered and in-flight data are discarded and the pointers return to 0. The write side must be reset in the same window; this block does not check that.
- **First-word latency:** `wr_ptr_gray` changes before edge N.
  - s2 updates at N+1; `empty` falls and `rd_en` rises in the cycle after N+1.
  - The BRAM registers at N+2; capture happens at N+3.
  - `m_valid` = 1 after edge N+3.
- **Throughput:** with `m_ready` held high and the FIFO non-empty, one word per cycle is sustained after the first.
- **Back-pressure:**
  - `m_ready` = 0 stops fetching once occ + inflight = 2.
  - When `m_ready` rises, a fetch reissues in the same cycle as the pop.
- **Full FIFO read:** 2^PTR_LEN words drain with the pointer MSB toggled. `empty` asserts when `rd_ptr_gray` == s2.
- **Pessimism:** `empty` and `level` reflect the write pointer two cycles late. They are never optimistic.

## Test plan
- **Reset:** assert `rd_rst_n` = 0 asynchronously mid-cycle → all outputs 0 immediately, `empty` = 1, and `m_valid` stays 0 after release.
- **Single word:** step `wr_ptr_gray` 0→1 with BRAM[0] = 0xA5 → `rd_en` for exactly one cycle at `read_ptr` = 0, `m_valid` 3 edges later with `m_data` = 0xA5, then `empty` = 1 and `rd_ptr_gray` = 1.
- **Streaming:** 16 words 0x00..0x0F with `m_ready` = 1 → in-order output, one per cycle after the first, and `read_ptr` = 16 (wrap bit set) with `level` = 0 at the end.
- **Back-pressure:** 5 words pending with `m_ready` = 0 → exactly 2 fetches, `level` = 3, and `m_data` held. Releasing `m_ready` → the remaining 3 words follow in order with no loss or duplicates.
- **Wrap:** start pointers at 30, write 4 words → `read_ptr` goes 30, 31, 0, 1, Gray outputs are correct, and data is in order.
- **Random:** `m_ready` toggled randomly against a scoreboard → no lost or duplicated words, and occ + inflight ≤ 2 always.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain side of the async FIFO; syncs the Gray write pointer, fetches from BRAM into a 2-entry valid/ready buffer
module fifo_rd_ctrl #(
  parameter int WIDTH   = 8,
  parameter int PTR_LEN = 4
) (
  input  logic               rd_clk,
  input  logic               rd_rst_n,
  input  logic [PTR_LEN:0]   wr_ptr_gray,
  output logic [PTR_LEN:0]   rd_ptr_gray,
  output logic [PTR_LEN:0]   read_ptr,
  output logic               rd_en,
  input  logic [WIDTH-1:0]   bram_data,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               empty,
  output logic [PTR_LEN:0]   level
);
  logic [PTR_LEN:0] s1, s2, sync_wr_bin, rd_nxt;
  logic [WIDTH-1:0] head, tail;
  logic [1:0]       occ;
  logic [2:0]       pending;
  logic             inflight, pop;

  function automatic logic [PTR_LEN:0] gray2bin(logic [PTR_LEN:0] g);
    logic [PTR_LEN:0] b;
    b[PTR_LEN] = g[PTR_LEN];
    for (int i = PTR_LEN - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign sync_wr_bin = gray2bin(s2);
  assign empty       = (s2 == rd_ptr_gray);
  assign level       = sync_wr_bin - read_ptr;
  assign m_data      = head;
  assign m_valid     = (occ != 2'd0);
  assign pop         = m_valid && m_ready;
  assign pending     = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign rd_en       = !empty && (pending < 3'd2);
  assign rd_nxt      = read_ptr + {{PTR_LEN{1'b0}}, 1'b1};

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      s1          <= '0;
      s2          <= '0;
      read_ptr    <= '0;
      rd_ptr_gray <= '0;
      inflight    <= 1'b0;
    end else begin
      s1       <= wr_ptr_gray;
      s2       <= s1;
      inflight <= rd_en;
      if (rd_en) begin
        read_ptr    <= rd_nxt;
        rd_ptr_gray <= rd_nxt ^ (rd_nxt >> 1);
      end
    end
  end

  // BRAM word is only present the cycle after rd_en, so it is captured unconditionally then
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (pop) head <= tail;
      if (inflight) begin
        if (occ - 2'(pop) == 2'd0) head <= bram_data;
        else tail <= bram_data;
      end
      occ <= occ + 2'(inflight) - 2'(pop);
    end
  end
endmodule
